// File: rtl/series_eval_ctrl.sv
// Sequencer for one series-evaluation pass: host start/result handshake, term counter
// start/stop, MAC enable aligned to coefficient valid, and a term-count cross-check.
module series_eval_ctrl #(
  parameter int CNTR_DEPTH = 5,
  parameter int ROM_LAT    = 1,
  parameter int MAC_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNTR_DEPTH-1:0] num_terms,
  input  logic                  abort,
  input  logic [CNTR_DEPTH-1:0] term_cnt,
  output logic                  start_cntr,
  output logic                  cntr_done,
  output logic                  acc_clr,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  err_zero,
  output logic                  err_sync
);

  localparam int                 DRAIN_W    = $clog2(ROM_LAT + MAC_LAT);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(ROM_LAT + MAC_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_RESULT} state_t;

  state_t                r_state;
  logic [CNTR_DEPTH-1:0] r_n;
  logic [CNTR_DEPTH-1:0] r_shadow;
  logic [DRAIN_W-1:0]    r_drain;
  logic [ROM_LAT-1:0]    r_dly;
  logic                  w_term_valid;
  logic                  w_last_term;

  assign w_term_valid = (r_state == S_RUN);
  assign w_last_term  = (r_shadow == r_n - CNTR_DEPTH'(1));
  assign mac_en       = r_dly[ROM_LAT-1];
  // An abort must stop the term counter in the same cycle, so this one is not registered.
  assign cntr_done    = w_term_valid && (w_last_term || abort);

  // NOTE: sequential state uses <= only, so every read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_shadow     <= '0;
      r_drain      <= '0;
      r_dly        <= '0;
      start_cntr   <= 1'b0;
      acc_clr      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err_zero     <= 1'b0;
      err_sync     <= 1'b0;
    end else begin
      start_cntr <= 1'b0;
      acc_clr    <= 1'b0;
      err_zero   <= 1'b0;
      r_dly[0]   <= w_term_valid;
      for (int i = 1; i < ROM_LAT; i++) r_dly[i] <= r_dly[i-1];

      if (abort && r_state != S_IDLE) begin
        r_state      <= S_IDLE;
        busy         <= 1'b0;
        result_valid <= 1'b0;
        r_dly        <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (num_terms != '0) begin
                r_n        <= num_terms;
                err_sync   <= 1'b0;
                acc_clr    <= 1'b1;
                start_cntr <= 1'b1;
                busy       <= 1'b1;
                r_state    <= S_CLR;
              end else begin
                err_zero <= 1'b1;
              end
            end
          end
          S_CLR: begin
            r_shadow <= '0;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            if (term_cnt != r_shadow) err_sync <= 1'b1;
            if (w_last_term) begin
              r_drain <= DRAIN_LOAD;
              r_state <= S_DRAIN;
            end else begin
              r_shadow <= r_shadow + CNTR_DEPTH'(1);
            end
          end
          S_DRAIN: begin
            if (r_drain == '0) begin
              result_valid <= 1'b1;
              r_state      <= S_RESULT;
            end else begin
              r_drain <= r_drain - DRAIN_W'(1);
            end
          end
          S_RESULT: begin
            if (result_ready) begin
              result_valid <= 1'b0;
              busy         <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_series_eval_ctrl.sv
// Directed bench for series_eval_ctrl: each pass is traced cycle by cycle into bit
// vectors (bit c = cycle c, start sampled in cycle 0) and compared to hand-derived masks.
module tb_series_eval_ctrl;

  localparam int CNTR_DEPTH = 5;
  localparam int ROM_LAT    = 1;
  localparam int MAC_LAT    = 2;
  localparam int NCYC       = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [CNTR_DEPTH-1:0] num_terms;
  logic                  abort;
  logic [CNTR_DEPTH-1:0] term_cnt;
  logic                  start_cntr;
  logic                  cntr_done;
  logic                  acc_clr;
  logic                  mac_en;
  logic                  busy;
  logic                  result_valid;
  logic                  result_ready;
  logic                  err_zero;
  logic                  err_sync;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tr_start_cntr, tr_cntr_done, tr_acc_clr, tr_mac_en;
  logic [31:0] tr_busy, tr_rv, tr_err_zero, tr_err_sync;

  series_eval_ctrl #(
    .CNTR_DEPTH(CNTR_DEPTH),
    .ROM_LAT   (ROM_LAT),
    .MAC_LAT   (MAC_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_terms   (num_terms),
    .abort       (abort),
    .term_cnt    (term_cnt),
    .start_cntr  (start_cntr),
    .cntr_done   (cntr_done),
    .acc_clr     (acc_clr),
    .mac_en      (mac_en),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .err_zero    (err_zero),
    .err_sync    (err_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // n is driven in cycle 0, n2 afterwards; s2 marks a second accepted start (0 = none),
  // used only to restart the modelled term counter; skip >= 0 makes it jump over that value.
  task automatic run(input logic [4:0] n, input logic [4:0] n2, input logic [31:0] start_vec,
                     input int s2, input logic [31:0] ready_vec, input logic [31:0] abort_vec,
                     input logic [31:0] rst_vec, input int skip);
    tr_start_cntr = '0; tr_cntr_done = '0; tr_acc_clr  = '0; tr_mac_en   = '0;
    tr_busy       = '0; tr_rv        = '0; tr_err_zero = '0; tr_err_sync = '0;
    for (int c = 0; c < NCYC; c++) begin
      int k;
      rst_n        = rst_vec[c];
      start        = start_vec[c];
      num_terms    = (c == 0) ? n : n2;
      abort        = abort_vec[c];
      result_ready = ready_vec[c];
      k = (s2 > 0 && c >= s2 + 2) ? c - s2 - 2 : c - 2;
      if (skip >= 0 && k >= skip) k++;
      term_cnt = k[4:0];
      #1;
      tr_start_cntr[c] = start_cntr;
      tr_cntr_done[c]  = cntr_done;
      tr_acc_clr[c]    = acc_clr;
      tr_mac_en[c]     = mac_en;
      tr_busy[c]       = busy;
      tr_rv[c]         = result_valid;
      tr_err_zero[c]   = err_zero;
      tr_err_sync[c]   = err_sync;
      @(posedge clk);
      #1;
    end
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b1;
    start        = 1'b1;
    num_terms    = 5'd4;
    abort        = 1'b1;
    term_cnt     = '0;
    result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs",
          {23'd0, start_cntr, cntr_done, acc_clr, mac_en, busy, result_valid, err_zero, err_sync},
          32'd0);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;

    // Nominal pass, n=4
    run(5'd4, 5'd4, 32'h1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, -1);
    check("nom_acc_clr",    tr_acc_clr,    32'h0000_0002);
    check("nom_start_cntr", tr_start_cntr, 32'h0000_0002);
    check("nom_cntr_done",  tr_cntr_done,  32'h0000_0020);
    check("nom_mac_en",     tr_mac_en,     32'h0000_0078);
    check("nom_busy",       tr_busy,       32'h0000_03FE);
    check("nom_result_vld", tr_rv,         32'h0000_0200);
    check("nom_err_sync",   tr_err_sync,   32'h0000_0000);

    // Single term, n=1
    run(5'd1, 5'd1, 32'h1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, -1);
    check("one_cntr_done",  tr_cntr_done, 32'h0000_0004);
    check("one_mac_en",     tr_mac_en,    32'h0000_0008);
    check("one_result_vld", tr_rv,        32'h0000_0040);
    check("one_busy",       tr_busy,      32'h0000_007E);

    // Back-pressure, n=3: ready low through cycle 12, stray starts and num_terms change while busy
    run(5'd3, 5'd31, 32'h0000_0A01, 0, 32'hFFFF_E000, 32'h0, 32'h0, -1);
    check("bp_cntr_done",  tr_cntr_done,  32'h0000_0010);
    check("bp_mac_en",     tr_mac_en,     32'h0000_0038);
    check("bp_result_vld", tr_rv,         32'h0000_3F00);
    check("bp_busy",       tr_busy,       32'h0000_3FFE);
    check("bp_start_cntr", tr_start_cntr, 32'h0000_0002);

    // Zero terms; abort while idle must do nothing
    run(5'd0, 5'd0, 32'h1, 0, 32'hFFFF_FFFF, 32'h0000_0008, 32'h0, -1);
    check("zero_err_zero",   tr_err_zero,   32'h0000_0002);
    check("zero_busy",       tr_busy,       32'h0000_0000);
    check("zero_start_cntr", tr_start_cntr, 32'h0000_0000);
    check("zero_acc_clr",    tr_acc_clr,    32'h0000_0000);

    // Abort in the 2nd RUN cycle (cycle 3), n=8
    run(5'd8, 5'd8, 32'h1, 0, 32'hFFFF_FFFF, 32'h0000_0008, 32'h0, -1);
    check("abort_cntr_done",  tr_cntr_done, 32'h0000_0008);
    check("abort_mac_en",     tr_mac_en,    32'h0000_0008);
    check("abort_busy",       tr_busy,      32'h0000_000E);
    check("abort_result_vld", tr_rv,        32'h0000_0000);

    // Sync error: counter skips value 2 (n=6), then a second 1-term pass at cycle 20 clears it
    run(5'd6, 5'd1, 32'h0010_0001, 20, 32'hFFFF_FFFF, 32'h0, 32'h0, 2);
    check("sync_err_sync",   tr_err_sync,   32'h001F_FFE0);
    check("sync_result_vld", tr_rv,         32'h0400_0800);
    check("sync_cntr_done",  tr_cntr_done,  32'h0040_0080);
    check("sync_start_cntr", tr_start_cntr, 32'h0020_0002);

    // Reset asserted in DRAIN (cycle 5), n=2
    run(5'd2, 5'd2, 32'h1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0020, -1);
    check("rst_busy",       tr_busy,      32'h0000_003E);
    check("rst_mac_en",     tr_mac_en,    32'h0000_0018);
    check("rst_cntr_done",  tr_cntr_done, 32'h0000_0008);
    check("rst_result_vld", tr_rv,        32'h0000_0000);
    check("rst_acc_clr",    tr_acc_clr,   32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
